// File: rtl/lms_ctr_led_ctrl.sv
// Memory-mapped LED controller with per-channel blink enable.
// A shared prescaled phase gates blinking channels and the LED output is registered.
module lms_ctr_led_ctrl #(
  parameter int unsigned            WIDTH      = 8,
  parameter int unsigned            PRESCALE_W = 24,
  parameter logic [PRESCALE_W-1:0]  PERIOD_RST = 24'd5_000_000,
  parameter logic [WIDTH-1:0]       OUT_INV    = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_MODE   = 3'd1;
  localparam logic [2:0] A_SET    = 3'd2;
  localparam logic [2:0] A_CLR    = 3'd3;
  localparam logic [2:0] A_PERIOD = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      mode_q, mode_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic [WIDTH-1:0]      led;
  logic                  wr_en;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect & ~write_n;

  // A blinking channel follows DATA only while the shared phase is high.
  assign led = data_q & (~mode_q | {WIDTH{phase_q}});

  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    out_d    = led ^ OUT_INV;

    if (wr_en) begin
      case (address)
        A_DATA:   data_d   = writedata[WIDTH-1:0];
        A_MODE:   mode_d   = writedata[WIDTH-1:0];
        A_SET:    data_d   = data_q | writedata[WIDTH-1:0];
        A_CLR:    data_d   = data_q & ~writedata[WIDTH-1:0];
        A_PERIOD: period_d = writedata[PRESCALE_W-1:0];
        default:  ;
      endcase
    end

    // A PERIOD write restarts the blink cycle from phase 0 with the new count.
    if (wr_en && (address == A_PERIOD)) begin
      cnt_d   = writedata[PRESCALE_W-1:0];
      phase_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d   = period_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q - PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      mode_q   <= '0;
      period_q <= PERIOD_RST;
      cnt_q    <= PERIOD_RST;
      phase_q  <= 1'b0;
      out_q    <= OUT_INV;
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      A_DATA:   readdata = 32'(data_q);
      A_MODE:   readdata = 32'(mode_q);
      A_PERIOD: readdata = 32'(period_q);
      A_STATUS: readdata = 32'(led);
      default:  readdata = 32'h0;
    endcase
  end

  assign out_port = out_q;

endmodule
